// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment byte order is {dp,g,f,e,d,c,b,a}, active-low.
package ssd_pkg;

   localparam logic [7:0] SSD_OFF   = 8'hFF;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   localparam logic [7:0] SEG_N = 8'b1010_1011;
   localparam logic [7:0] SEG_T = 8'b1000_0111;
   localparam logic [7:0] SEG_H = 8'b1000_1001;
   localparam logic [7:0] SEG_U = 8'b1100_0001;
   localparam logic [7:0] SEG_E = 8'b1000_0110;

   typedef struct packed {
      logic [31:0] pat;
      logic [2:0]  dim;
   } ssd_buf_t;

   localparam ssd_buf_t BUF_RST = '{pat: {4{SSD_OFF}}, dim: 3'd7};

   function automatic logic [3:0] anode_of(input logic [1:0] d);
      logic [3:0] a;
      a = ANODE_OFF;
      unique case (d)
         2'd0: a = 4'b0111;
         2'd1: a = 4'b1011;
         2'd2: a = 4'b1101;
         2'd3: a = 4'b1110;
      endcase
      return a;
   endfunction

   function automatic logic [7:0] seg_of(
      input logic [31:0] pat,
      input logic [1:0]  d
   );
      logic [7:0] s;
      s = SSD_OFF;
      unique case (d)
         2'd0: s = pat[31:24];
         2'd1: s = pat[23:16];
         2'd2: s = pat[15:8];
         2'd3: s = pat[7:0];
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Scan timebase: sub-eighth counter, PWM eighth and digit slot.
// Ports: clk, rst (sync, high) in; digit, eighth, fb (frame boundary) out.
module ssd_scan_timer #(
   parameter int SUB_DIV = 12500,
   parameter int CNT_W   = 14
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] digit,
   output logic [2:0] eighth,
   output logic       fb
);

   logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
   logic [2:0]       eighth_q, eighth_d;
   logic [1:0]       digit_q, digit_d;
   logic             sub_wrap;

   always_comb begin
      sub_wrap  = (sub_cnt_q == CNT_W'(SUB_DIV - 1));
      sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
      eighth_d  = sub_wrap ? eighth_q + 3'd1 : eighth_q;
      digit_d   = digit_q;
      if (sub_wrap && eighth_q == 3'd7)
         digit_d = digit_q + 2'd1;
      fb = sub_wrap && (eighth_q == 3'd7) && (digit_q == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_cnt_q <= '0;
         eighth_q  <= '0;
         digit_q   <= '0;
      end else begin
         sub_cnt_q <= sub_cnt_d;
         eighth_q  <= eighth_d;
         digit_q   <= digit_d;
      end
   end

   assign digit  = digit_q;
   assign eighth = eighth_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed display driver with double buffering and PWM dim.
// Ports: clk, rst, digits[31:0], load, dim[2:0], blink in;
//   show[7:0], ssd_ctrl[3:0] (active-low), frame_done out.
// Optional blink (32 frames on / 32 off) enabled by macro SSD_BLINK_EN.
module ssd_scan_driver import ssd_pkg::*; #(
   parameter int SUB_DIV = 12500,
   parameter int CNT_W   = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] digits,
   input  logic        load,
   input  logic [2:0]  dim,
   input  logic        blink,
   output logic [7:0]  show,
   output logic [3:0]  ssd_ctrl,
   output logic        frame_done
);

   logic [1:0] digit;
   logic [2:0] eighth;
   logic       fb;

   ssd_scan_timer #(
      .SUB_DIV (SUB_DIV),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .digit  (digit),
      .eighth (eighth),
      .fb     (fb)
   );

   ssd_buf_t   pend_q, pend_d;
   ssd_buf_t   act_q, act_d;
   ssd_buf_t   new_buf;
   logic       dirty_q, dirty_d;
   logic [7:0] show_q, show_d;
   logic [3:0] ctrl_q, ctrl_d;
   logic       done_q, done_d;
   logic       lit;
   logic       dark;

`ifdef SSD_BLINK_EN
   logic [5:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = fb ? frame_cnt_q + 6'd1 : frame_cnt_q;
      dark        = blink && frame_cnt_q[5];
   end

   always_ff @(posedge clk) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end
`else
   logic blink_unused;
   assign blink_unused = blink;
   assign dark = 1'b0;
`endif

   always_comb begin
      new_buf.pat = digits;
      new_buf.dim = dim;
      pend_d  = load ? new_buf : pend_q;
      act_d   = act_q;
      dirty_d = dirty_q;
      if (fb) begin
         // A load landing on the boundary bypasses pending.
         if (load)         act_d = new_buf;
         else if (dirty_q) act_d = pend_q;
         dirty_d = 1'b0;
      end else if (load) begin
         dirty_d = 1'b1;
      end

      lit    = (eighth <= act_q.dim) && !dark;
      show_d = lit ? seg_of(act_q.pat, digit) : SSD_OFF;
      ctrl_d = lit ? anode_of(digit) : ANODE_OFF;
      done_d = fb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= BUF_RST;
         act_q   <= BUF_RST;
         dirty_q <= 1'b0;
         show_q  <= SSD_OFF;
         ctrl_q  <= ANODE_OFF;
         done_q  <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         act_q   <= act_d;
         dirty_q <= dirty_d;
         show_q  <= show_d;
         ctrl_q  <= ctrl_d;
         done_q  <= done_d;
      end
   end

   assign show       = show_q;
   assign ssd_ctrl   = ctrl_q;
   assign frame_done = done_q;

endmodule
